lca_pipe_accumulator: RTL
=========================

Name: lca_pipe_accumulator

Overview:
- Parametrised, pipelined carry-lookahead accumulator: the phase/error accumulator stage of the DDSM (one MASH-1 stage).
- Each enabled cycle it adds input word i_x to an internal WIDTH-bit accumulator.
- The accumulator is split into 4-bit lookahead segments; segment carries are pipelined, so the critical path is one 4-bit lookahead regardless of WIDTH.
- Outputs are deskewed sum and overflow carry (the 1-bit modulator output); cascades directly into the next MASH stage.

Parameters:
- WIDTH, 24, accumulator/input width in bits; must be a multiple of 4 and at least 8 (elaboration-time check, fatal otherwise).
- SEG_W, 4, segment width; fixed at 4, not to be overridden.
- NSEG, WIDTH/SEG_W, derived number of segments; also the pipeline latency in enabled cycles.

Ports:
- i_clk  input  1  clock; all state is updated on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_en  input  1  clock enable. High: i_x is captured and every pipeline/accumulator register advances. Low: all state holds.
- i_clr  input  1  synchronous clear of accumulator and pipeline; same effect as i_rst, evaluated only when i_rst is low.
- i_x  input  WIDTH  unsigned increment word, sampled on enabled edges.
- o_sum  output  WIDTH  deskewed accumulator value after the sample's addition.
- o_carry  output  1  overflow carry of that addition (MASH output bit).
- o_carry_seg  output  NSEG  deskewed per-segment carry-outs of that addition. Bit k is the carry out of bits [4k+3:4k]; bit NSEG-1 equals o_carry.
- o_valid  output  1  high when the output registers hold a completed sample.

Behaviour:
- Clock/reset: one clock domain (i_clk). i_rst is synchronous and active-high; it dominates i_clr and i_en.
- Reset/clear state: all outputs are 0 and stay 0 until refilled. This covers o_sum, o_carry, o_carry_seg, o_valid, all segment accumulators, skew/deskew registers, carry pipeline registers and the fill counter.
- Reference model: acc[0] = 0. For each enabled sample n: {c[n], acc[n+1]} = acc[n] + x[n], with acc kept mod 2^WIDTH and c[n] the carry out of bit WIDTH-1.
- Input skew: segment k of x[n] is delayed k enabled cycles.
- Segment k update: at each enabled edge it computes (its accumulator) + (skewed x segment) + (registered carry from segment k-1 of the previous enabled edge). Segment 0 uses carry-in 0.
- Segment k output: it registers the 4-bit result and its carry; the carry feeds segment k+1.
- Lookahead: inside each segment, generate = a&b and propagate = a^b; carries are two-level lookahead, with no ripple across bits.
- Deskew and latency: sample captured at enabled edge E appears on o_sum/o_carry/o_carry_seg immediately after enabled edge E+NSEG. The result is bit-exact to the reference model.
- Stalls: i_en low freezes everything, outputs included. Latency counts enabled edges only. Samples presented while i_en is low are ignored.
- o_valid:
  - Fill counter counts enabled edges after reset/clear and saturates at NSEG+1.
  - o_valid = (count == NSEG+1); it stays high through stalls.
  - Outputs while o_valid is low are 0-derived fill values and must not be consumed.
- Wrap-around: accumulator overflow is modular. There is no saturation; the carry is the only overflow indication.
- Clear mid-operation: every in-flight sample is discarded; the first sample after clear is treated as n=0 with acc=0.
- i_clr and i_en high together: clear wins; i_x is not captured.

Decomposition:
- Shared package (ddsm_pkg): SEG_W=4 constant; function computing NSEG; WIDTH legality check function.
- Sub-module lca_seg4:
  - Inputs: 4-bit a, b, cin. Outputs: 4-bit sum, cout.
  - Purely combinational two-level lookahead.
  - Instantiated NSEG times via generate.
- All registers live in the top level: skew triangle, segment accumulators, carry pipe, deskew triangle, fill counter.

Test Plan:
1. WIDTH=24, i_en=1, i_x=24'h400000 constant from reset:
   - o_valid rises after 7 enabled edges.
   - o_carry sequence is 0,0,0,1 repeating.
   - o_sum cycles 400000, 800000, C00000, 000000.
2. WIDTH=8, i_x=8'hFF then 8'h01 -> o_sum=FF with carry 0, then 00 with carry 1; o_carry_seg=2'b11 on the second sample (full cross-segment propagate).
3. WIDTH=24, random i_x with random i_en gaps (about 30% low) over 10^5 samples -> bit-exact match to the reference model. Outputs are frozen on every i_en=0 cycle.
4. WIDTH=24, x=24'h155555 running; i_clr pulsed mid-stream -> all outputs 0 and o_valid low on the next edge. Refill takes 7 enabled edges; the first valid o_sum equals the first post-clear i_x.
5. i_rst asserted together with i_en=1 and i_clr=0 -> reset state on the next edge; the i_x presented at that edge is never observed at the outputs.
6. WIDTH=32, i_x=32'h00000001 with acc pre-driven to FFFFFFFF via 2^32-1 ones (shortened by first loading i_x=FFFFFFFF once) -> the next sample gives o_sum=0, o_carry=1, o_carry_seg all ones.

Source files
------------

// File: rtl/ddsm_pkg.sv
// Shared constants and elaboration helpers for the DDSM accumulator stages.
package ddsm_pkg;
  localparam int SEG_W = 4;

  function automatic int calc_nseg(input int width);
    return width / SEG_W;
  endfunction

  // Width must split into whole lookahead segments and give at least two of them.
  function automatic bit width_legal(input int width);
    return ((width % SEG_W) == 0) && (width >= 2 * SEG_W);
  endfunction
endpackage

// File: rtl/lca_seg4.sv
// 4-bit two-level carry-lookahead adder slice; purely combinational.
module lca_seg4
  import ddsm_pkg::*;
(
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/cin, so no carry waits on another.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/lca_pipe_accumulator.sv
// Pipelined carry-lookahead accumulator (one MASH-1 stage): segment carries are
// registered between 4-bit slices, with input skew and output deskew triangles.
module lca_pipe_accumulator
  import ddsm_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic [WIDTH-1:0]       i_x,
  output logic [WIDTH-1:0]       o_sum,
  output logic                   o_carry,
  output logic [WIDTH/SEG_W-1:0] o_carry_seg,
  output logic                   o_valid
);
  localparam int NSEG  = calc_nseg(WIDTH);
  localparam int CNT_W = $clog2(NSEG + 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NSEG + 1);

  if (!width_legal(WIDTH)) begin : g_width_chk
    $fatal(1, "lca_pipe_accumulator: WIDTH must be a multiple of 4 and at least 8");
  end

  logic             flush;
  logic [NSEG-1:0]  cin_v;
  logic [CNT_W-1:0] fill_cnt;

  assign flush    = i_rst | i_clr;
  assign cin_v[0] = 1'b0;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int DSK = NSEG - 1 - k;

    logic [SEG_W-1:0] x_p0 [0:k];
    logic [SEG_W-1:0] acc_p1;
    logic [SEG_W-1:0] add_sum;
    logic             cy_p1;
    logic             add_cout;

    // Stage p0: input skew, segment k of a sample waits k enabled edges.
    always_ff @(posedge i_clk) begin
      if (flush) begin
        for (int j = 0; j <= k; j++) x_p0[j] <= '0;
      end else if (i_en) begin
        x_p0[0] <= i_x[k*SEG_W +: SEG_W];
        for (int j = 1; j <= k; j++) x_p0[j] <= x_p0[j-1];
      end
    end

    lca_seg4 u_seg (
      .a    (acc_p1),
      .b    (x_p0[k]),
      .cin  (cin_v[k]),
      .sum  (add_sum),
      .cout (add_cout)
    );

    // Stage p1: segment accumulator plus registered carry toward segment k+1.
    always_ff @(posedge i_clk) begin
      if (flush) begin
        acc_p1 <= '0;
        cy_p1  <= 1'b0;
      end else if (i_en) begin
        acc_p1 <= add_sum;
        cy_p1  <= add_cout;
      end
    end

    if (k < NSEG - 1) begin : g_cy
      assign cin_v[k+1] = cy_p1;
    end

    if (DSK == 0) begin : g_direct
      assign o_sum[k*SEG_W +: SEG_W] = acc_p1;
      assign o_carry_seg[k]          = cy_p1;
    end else begin : g_deskew
      logic [SEG_W-1:0] sum_p2 [0:DSK-1];
      logic [DSK-1:0]   cy_p2;

      // Stage p2: deskew so every segment of a sample leaves together.
      always_ff @(posedge i_clk) begin
        if (flush) begin
          for (int j = 0; j < DSK; j++) sum_p2[j] <= '0;
          cy_p2 <= '0;
        end else if (i_en) begin
          sum_p2[0] <= acc_p1;
          cy_p2[0]  <= cy_p1;
          for (int j = 1; j < DSK; j++) begin
            sum_p2[j] <= sum_p2[j-1];
            cy_p2[j]  <= cy_p2[j-1];
          end
        end
      end

      assign o_sum[k*SEG_W +: SEG_W] = sum_p2[DSK-1];
      assign o_carry_seg[k]          = cy_p2[DSK-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (flush) begin
      fill_cnt <= '0;
    end else if (i_en && (fill_cnt != FULL)) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  assign o_carry = o_carry_seg[NSEG-1];
  assign o_valid = (fill_cnt == FULL);
endmodule
